mem_bus_seq: RTL and testbench
==============================

Name: mem_bus_seq

Overview:
- Memory/IO bus sequencer directly downstream of the execution stage.
- Takes the stage's `addr`, `wr_data`, `we`, `m_io`, `byteop` and memory-op strobe, and runs one or two 16-bit bus cycles on the external Wishbone-style bus.
- Returns `memout` and a one-cycle `mem_rdy` that releases the execution stage's block.
- Word accesses at odd addresses are split into two byte-lane cycles.

Parameters:
- WAIT_MAX, 255: wait-state limit per bus cycle; on expiry the access is aborted with a bus error. Range 1..65535; counter width = clog2(WAIT_MAX+1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  1  memory operation requested (exec `mem_op`); held stable until `mem_rdy`
- addr  input  20  byte address (memory) or port address in [15:0] (IO)
- wr_data  input  16  write data; byte writes use [7:0]
- we  input  1  1 = write, 0 = read
- m_io  input  1  1 = IO space, 0 = memory space
- byteop  input  1  1 = byte access, 0 = word access
- memout  output  16  read data, valid in the `mem_rdy` cycle and held until next completion
- mem_rdy  output  1  one-cycle completion pulse
- bus_err  output  1  one-cycle pulse with `mem_rdy` when a timeout aborted the access
- wb_adr_o  output  19  word address (byte address [19:1])
- wb_sel_o  output  2  byte lane enables; [0] = even byte, [1] = odd byte
- wb_dat_o  output  16  write data on lanes
- wb_dat_i  input  16  read data on lanes
- wb_we_o  output  1  write enable
- wb_tga_o  output  1  IO-space tag (copy of `m_io`)
- wb_stb_o  output  1  strobe
- wb_cyc_o  output  1  cycle valid
- wb_ack_i  input  1  slave acknowledge; may assert in the first cycle of `stb`

Behaviour:
- Reset values (asynchronous, `rst` = 0):
  - state IDLE
  - `wb_stb_o` = `wb_cyc_o` = `wb_we_o` = `wb_tga_o` = 0
  - `wb_sel_o` = 0, `wb_adr_o` = 0, `wb_dat_o` = 0
  - `memout` = 0, `mem_rdy` = 0, `bus_err` = 0, wait counter = 0
- Request latching:
  - In IDLE, `req` = 1 latches `addr`, `wr_data`, `we`, `m_io`, `byteop`.
  - `split` = !byteop & addr[0].
  - Next state is BUS1. All bus outputs are registered.
- BUS1 drives `stb` = `cyc` = 1, `adr` = addr[19:1], `we`, `tga`. Lane selection:
  - byteop, addr[0] = 0: sel = 01, dat_o = {8'h00, wr_data[7:0]}
  - byteop, addr[0] = 1: sel = 10, dat_o = {wr_data[7:0], 8'h00}
  - word, even: sel = 11, dat_o = wr_data
  - split: sel = 10, dat_o = {wr_data[7:0], 8'h00}
- On `ack` in BUS1:
  - Capture the read byte or word: even byte from dat_i[7:0], odd byte from dat_i[15:8], split low byte from dat_i[15:8].
  - If split, go to BUS2; otherwise go to DONE.
- BUS2 (split only): `stb`/`cyc` stay high with no idle cycle.
  - adr = addr[19:1] + 1, wrapping modulo 2^19 (0x7FFFF → 0x00000).
  - For IO, the increment wraps within port space: adr[14:0] only, adr[18:15] = 0, so port 0xFFFF+1 → 0x0000.
  - sel = 01, dat_o = {8'h00, wr_data[15:8]}.
  - Split high byte is taken from dat_i[7:0]. On `ack`, go to DONE.
- DONE:
  - `stb` = `cyc` = 0.
  - `mem_rdy` = 1 for exactly one cycle.
  - `memout` is updated from registered data: byte reads → {8'h00, byte}; writes leave `memout` unchanged.
  - Next state is IDLE. A `req` seen in that IDLE cycle starts a new access.
- Latency, zero-wait slave:
  - Aligned access: `req` sampled at edge 0, `stb` high in cycle 1, `mem_rdy` in cycle 2.
  - Split access: `mem_rdy` in cycle 3.
  - Each wait state adds one cycle.
- Timeout:
  - The wait counter clears on entry to each bus cycle and increments every cycle `stb` is high without `ack`.
  - When the counter reaches WAIT_MAX without `ack`, go to DONE with `memout` = 16'hFFFF and `bus_err` = 1. A split access skips BUS2.
  - `ack` in the same cycle the counter hits WAIT_MAX counts as success.
- Boundary rules:
  - `req` deasserting mid-transaction is ignored; the access completes and `mem_rdy` still pulses.
  - Input changes after latching have no effect.
  - `wb_ack_i` while `stb` = 0 is ignored.
  - Asynchronous reset mid-transaction drops `stb`/`cyc` immediately; no `mem_rdy` is issued.

Test Plan:
- Aligned word read: addr=0x12344, zero-wait slave returns 0xBEEF → adr=0x091A2, sel=11, `mem_rdy` 2 cycles after `req`, memout=0xBEEF.
- Odd byte write: addr=0x00101, wr_data=0x00A5, byteop=1 → sel=10, dat_o=0xA500, we=1, `mem_rdy` pulse, memout unchanged.
- Split word read: addr=0x7FFFF, slave returns 0x3400 at adr 0x3FFFF, then 0x0012 at adr 0x40000 → memout=0x1234, `mem_rdy` at cycle 3.
- IO split write wrap: m_io=1, addr=0x0FFFF, wr_data=0xCAFE → cycle 1 adr=0x07FFF, sel=10, dat=0xFE00; cycle 2 adr=0x00000, sel=01, dat=0x00CA; tga=1 throughout.
- Timeout with WAIT_MAX=4: slave never acks → `stb` high exactly 4 cycles, then `mem_rdy`=`bus_err`=1, memout=0xFFFF. Rerun with ack in the 4th cycle → success, `bus_err`=0.
- Back-to-back and reset: `req` held high after `mem_rdy` → new access starts in the IDLE cycle. Assert `rst`=0 during BUS1 → `stb`/`cyc` drop asynchronously, no `mem_rdy`; after release, a fresh read completes normally.

Source files
------------

// File: rtl/mem_bus_seq.sv
// Memory/IO bus sequencer sitting after the execution stage.
// Converts one latched memory/IO request into one or two 16-bit
// Wishbone-style bus cycles. Odd-address word accesses are split into an
// odd-lane cycle followed by an even-lane cycle at the next word address.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req             memory operation request, held until mem_rdy
//   addr, wr_data   byte/port address and write data
//   we, m_io, byteop  write, IO-space and byte-access qualifiers
//   memout          read data, updated in the mem_rdy cycle
//   mem_rdy         one-cycle completion pulse
//   bus_err         one-cycle pulse with mem_rdy on wait-state timeout
//   wb_*            registered bus master interface
module mem_bus_seq #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [19:0] addr,
    input  logic [15:0] wr_data,
    input  logic        we,
    input  logic        m_io,
    input  logic        byteop,
    output logic [15:0] memout,
    output logic        mem_rdy,
    output logic        bus_err,
    output logic [18:0] wb_adr_o,
    output logic [1:0]  wb_sel_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUS1, BUS2, DONE} state_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
        logic        we;
        logic        io;
        logic        byteop;
        logic        split;
    } req_t;

    state_t        state_q, state_d;
    req_t          req_q, req_d;
    logic [7:0]    lo_q, lo_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] wait_inc;
    logic          wait_hit;
    logic [18:0]   adr_next;

    logic [18:0] adr_d;
    logic [1:0]  sel_d;
    logic [15:0] dat_d;
    logic        we_d, tga_d, stb_d, cyc_d;
    logic [15:0] memout_d;
    logic        rdy_d, err_d;

    assign wait_inc = wait_q + CW'(1);
    assign wait_hit = (wait_inc == CW'(WAIT_MAX));

    // Second word of a split access; IO increments wrap inside port space.
    assign adr_next = req_q.io ? {4'b0000, req_q.addr[15:1] + 15'd1}
                               : req_q.addr[19:1] + 19'd1;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        lo_d     = lo_q;
        wait_d   = wait_q;
        adr_d    = wb_adr_o;
        sel_d    = wb_sel_o;
        dat_d    = wb_dat_o;
        we_d     = wb_we_o;
        tga_d    = wb_tga_o;
        stb_d    = wb_stb_o;
        cyc_d    = wb_cyc_o;
        memout_d = memout;
        rdy_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    req_d.addr   = addr;
                    req_d.data   = wr_data;
                    req_d.we     = we;
                    req_d.io     = m_io;
                    req_d.byteop = byteop;
                    req_d.split  = !byteop && addr[0];
                    state_d = BUS1;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    adr_d   = addr[19:1];
                    we_d    = we;
                    tga_d   = m_io;
                    wait_d  = '0;
                    // Odd byte and first half of a split both use the odd lane.
                    if (addr[0]) begin
                        sel_d = 2'b10;
                        dat_d = {wr_data[7:0], 8'h00};
                    end else if (byteop) begin
                        sel_d = 2'b01;
                        dat_d = {8'h00, wr_data[7:0]};
                    end else begin
                        sel_d = 2'b11;
                        dat_d = wr_data;
                    end
                end
            end

            BUS1: begin
                if (wb_ack_i) begin
                    if (req_q.split) begin
                        state_d = BUS2;
                        lo_d    = wb_dat_i[15:8];
                        adr_d   = adr_next;
                        sel_d   = 2'b01;
                        dat_d   = {8'h00, req_q.data[15:8]};
                        wait_d  = '0;
                    end else begin
                        state_d = DONE;
                        stb_d   = 1'b0;
                        cyc_d   = 1'b0;
                        rdy_d   = 1'b1;
                        if (!req_q.we) begin
                            if (!req_q.byteop)
                                memout_d = wb_dat_i;
                            else if (req_q.addr[0])
                                memout_d = {8'h00, wb_dat_i[15:8]};
                            else
                                memout_d = {8'h00, wb_dat_i[7:0]};
                        end
                    end
                end else if (wait_hit) begin
                    state_d  = DONE;
                    stb_d    = 1'b0;
                    cyc_d    = 1'b0;
                    rdy_d    = 1'b1;
                    err_d    = 1'b1;
                    memout_d = 16'hFFFF;
                    wait_d   = wait_inc;
                end else begin
                    wait_d = wait_inc;
                end
            end

            BUS2: begin
                if (wb_ack_i) begin
                    state_d = DONE;
                    stb_d   = 1'b0;
                    cyc_d   = 1'b0;
                    rdy_d   = 1'b1;
                    if (!req_q.we)
                        memout_d = {wb_dat_i[7:0], lo_q};
                end else if (wait_hit) begin
                    state_d  = DONE;
                    stb_d    = 1'b0;
                    cyc_d    = 1'b0;
                    rdy_d    = 1'b1;
                    err_d    = 1'b1;
                    memout_d = 16'hFFFF;
                    wait_d   = wait_inc;
                end else begin
                    wait_d = wait_inc;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            lo_q     <= '0;
            wait_q   <= '0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_tga_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            memout   <= '0;
            mem_rdy  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            lo_q     <= lo_d;
            wait_q   <= wait_d;
            wb_adr_o <= adr_d;
            wb_sel_o <= sel_d;
            wb_dat_o <= dat_d;
            wb_we_o  <= we_d;
            wb_tga_o <= tga_d;
            wb_stb_o <= stb_d;
            wb_cyc_o <= cyc_d;
            memout   <= memout_d;
            mem_rdy  <= rdy_d;
            bus_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_seq.sv
// Directed bench for mem_bus_seq (WAIT_MAX = 4). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_mem_bus_seq;

    logic        clk;
    logic        rst;
    logic        req;
    logic [19:0] addr;
    logic [15:0] wr_data;
    logic        we;
    logic        m_io;
    logic        byteop;
    logic [15:0] memout;
    logic        mem_rdy;
    logic        bus_err;
    logic [18:0] wb_adr_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_we_o;
    logic        wb_tga_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_seq #(.WAIT_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .wr_data  (wr_data),
        .we       (we),
        .m_io     (m_io),
        .byteop   (byteop),
        .memout   (memout),
        .mem_rdy  (mem_rdy),
        .bus_err  (bus_err),
        .wb_adr_o (wb_adr_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_tga_o (wb_tga_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: through the rising edge to the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [19:0] a, input logic [15:0] d,
                         input logic w, input logic io, input logic b);
        req = 1'b1; addr = a; wr_data = d; we = w; m_io = io; byteop = b;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b0; addr = '0; wr_data = '0; we = 1'b0;
        m_io = 1'b0; byteop = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
        step();
        n_checks++;
        if ({wb_stb_o, wb_cyc_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o,
             memout, mem_rdy, bus_err} !== 61'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: stb=%b cyc=%b we=%b tga=%b sel=%b adr=%h dat=%h memout=%h rdy=%b err=%b, required all zero",
                     wb_stb_o, wb_cyc_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o, memout, mem_rdy, bus_err);
        end
        rst = 1'b1;
        step();
        // Stray ack while idle must not start or complete anything.
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        step();
        n_checks++;
        if ({wb_stb_o, mem_rdy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: stb=%b rdy=%b, required 0 0", wb_stb_o, mem_rdy);
        end
    endtask

    task automatic test_word_read();
        start(20'h12344, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++;
        if ({wb_stb_o, wb_cyc_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, mem_rdy} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 19'h091A2, 1'b0}) begin
            n_fail++;
            $display("FAIL word_read_bus: stb=%b cyc=%b we=%b tga=%b sel=%b adr=%h rdy=%b, required 1 1 0 0 11 091a2 0",
                     wb_stb_o, wb_cyc_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, mem_rdy);
        end
        wb_ack_i = 1'b1; wb_dat_i = 16'hBEEF; req = 1'b0;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, bus_err, wb_stb_o, wb_cyc_o, memout} !== {4'b1000, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL word_read_done: rdy=%b err=%b stb=%b cyc=%b memout=%h, required 1 0 0 0 beef",
                     mem_rdy, bus_err, wb_stb_o, wb_cyc_o, memout);
        end
        step();
        n_checks++;
        if ({mem_rdy, wb_stb_o, memout} !== {2'b00, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL word_read_after: rdy=%b stb=%b memout=%h, required 0 0 beef", mem_rdy, wb_stb_o, memout);
        end
    endtask

    // Odd byte write with one wait state; inputs are scrambled after latching.
    task automatic test_byte_write();
        start(20'h00101, 16'h00A5, 1'b1, 1'b0, 1'b1);
        step();
        n_checks++;
        if ({wb_stb_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o} !==
            {1'b1, 1'b1, 1'b0, 2'b10, 19'h00080, 16'hA500}) begin
            n_fail++;
            $display("FAIL byte_write_bus: stb=%b we=%b tga=%b sel=%b adr=%h dat=%h, required 1 1 0 10 00080 a500",
                     wb_stb_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o);
        end
        req = 1'b0; addr = 20'h00000; wr_data = 16'hFFFF; we = 1'b0; byteop = 1'b0;
        step();
        n_checks++;
        if ({wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, mem_rdy} !==
            {1'b1, 1'b1, 2'b10, 19'h00080, 16'hA500, 1'b0}) begin
            n_fail++;
            $display("FAIL byte_write_wait: stb=%b we=%b sel=%b adr=%h dat=%h rdy=%b, required 1 1 10 00080 a500 0",
                     wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, mem_rdy);
        end
        wb_ack_i = 1'b1; wb_dat_i = 16'h7777;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, bus_err, wb_stb_o, memout} !== {3'b100, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL byte_write_done: rdy=%b err=%b stb=%b memout=%h, required 1 0 0 beef",
                     mem_rdy, bus_err, wb_stb_o, memout);
        end
        step();
    endtask

    task automatic test_byte_read();
        start(20'h00200, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        n_checks++;
        if ({wb_sel_o, wb_adr_o} !== {2'b01, 19'h00100}) begin
            n_fail++;
            $display("FAIL byte_read_even_bus: sel=%b adr=%h, required 01 00100", wb_sel_o, wb_adr_o);
        end
        wb_ack_i = 1'b1; wb_dat_i = 16'h5A3C; req = 1'b0;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, memout} !== {1'b1, 16'h003C}) begin
            n_fail++;
            $display("FAIL byte_read_even: rdy=%b memout=%h, required 1 003c", mem_rdy, memout);
        end
        step();
        start(20'h00201, 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 16'h5A3C; req = 1'b0;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, memout} !== {1'b1, 16'h005A}) begin
            n_fail++;
            $display("FAIL byte_read_odd: rdy=%b memout=%h, required 1 005a", mem_rdy, memout);
        end
        step();
    endtask

    task automatic test_split_read();
        start(20'h7FFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        n_checks++;
        if ({wb_stb_o, wb_sel_o, wb_adr_o} !== {1'b1, 2'b10, 19'h3FFFF}) begin
            n_fail++;
            $display("FAIL split_read_c1: stb=%b sel=%b adr=%h, required 1 10 3ffff", wb_stb_o, wb_sel_o, wb_adr_o);
        end
        wb_ack_i = 1'b1; wb_dat_i = 16'h3400; req = 1'b0;
        step();
        n_checks++;
        if ({wb_stb_o, wb_cyc_o, wb_sel_o, wb_adr_o, mem_rdy} !== {1'b1, 1'b1, 2'b01, 19'h40000, 1'b0}) begin
            n_fail++;
            $display("FAIL split_read_c2: stb=%b cyc=%b sel=%b adr=%h rdy=%b, required 1 1 01 40000 0",
                     wb_stb_o, wb_cyc_o, wb_sel_o, wb_adr_o, mem_rdy);
        end
        wb_dat_i = 16'h0012;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, bus_err, wb_stb_o, memout} !== {3'b100, 16'h1234}) begin
            n_fail++;
            $display("FAIL split_read_done: rdy=%b err=%b stb=%b memout=%h, required 1 0 0 1234",
                     mem_rdy, bus_err, wb_stb_o, memout);
        end
        step();
        // Memory word address wraps modulo 2^19.
        start(20'hFFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 16'h0000; req = 1'b0;
        step();
        n_checks++;
        if ({wb_sel_o, wb_adr_o} !== {2'b01, 19'h00000}) begin
            n_fail++;
            $display("FAIL split_mem_wrap: sel=%b adr=%h, required 01 00000", wb_sel_o, wb_adr_o);
        end
        step();
        wb_ack_i = 1'b0;
        step();
    endtask

    task automatic test_io_split_write();
        start(20'h0FFFF, 16'hCAFE, 1'b1, 1'b1, 1'b0);
        step();
        n_checks++;
        if ({wb_stb_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o} !==
            {1'b1, 1'b1, 1'b1, 2'b10, 19'h07FFF, 16'hFE00}) begin
            n_fail++;
            $display("FAIL io_split_c1: stb=%b we=%b tga=%b sel=%b adr=%h dat=%h, required 1 1 1 10 07fff fe00",
                     wb_stb_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o);
        end
        wb_ack_i = 1'b1; req = 1'b0;
        step();
        n_checks++;
        if ({wb_stb_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o} !==
            {1'b1, 1'b1, 1'b1, 2'b01, 19'h00000, 16'h00CA}) begin
            n_fail++;
            $display("FAIL io_split_c2: stb=%b we=%b tga=%b sel=%b adr=%h dat=%h, required 1 1 1 01 00000 00ca",
                     wb_stb_o, wb_we_o, wb_tga_o, wb_sel_o, wb_adr_o, wb_dat_o);
        end
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, bus_err, memout} !== {2'b10, 16'h0000}) begin
            n_fail++;
            $display("FAIL io_split_done: rdy=%b err=%b memout=%h, required 1 0 0000", mem_rdy, bus_err, memout);
        end
        step();
    endtask

    task automatic test_timeout();
        start(20'h00010, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            req = 1'b0;
            n_checks++;
            if ({wb_stb_o, mem_rdy} !== 2'b10) begin
                n_fail++;
                $display("FAIL timeout_stb_cycle%0d: stb=%b rdy=%b, required 1 0", i, wb_stb_o, mem_rdy);
            end
        end
        step();
        n_checks++;
        if ({mem_rdy, bus_err, wb_stb_o, wb_cyc_o, memout} !== {4'b1100, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL timeout_done: rdy=%b err=%b stb=%b cyc=%b memout=%h, required 1 1 0 0 ffff",
                     mem_rdy, bus_err, wb_stb_o, wb_cyc_o, memout);
        end
        step();
        n_checks++;
        if ({mem_rdy, bus_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_pulse_width: rdy=%b err=%b, required 0 0", mem_rdy, bus_err);
        end
        // Ack in the last permitted cycle is a success.
        start(20'h00010, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            req = 1'b0;
        end
        step();
        wb_ack_i = 1'b1; wb_dat_i = 16'h1357;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, bus_err, memout} !== {2'b10, 16'h1357}) begin
            n_fail++;
            $display("FAIL timeout_edge_ack: rdy=%b err=%b memout=%h, required 1 0 1357", mem_rdy, bus_err, memout);
        end
        step();
        // Split access that times out in its first half skips the second.
        start(20'h00021, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            req = 1'b0;
        end
        step();
        n_checks++;
        if ({mem_rdy, bus_err, wb_stb_o, memout} !== {3'b110, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL timeout_split: rdy=%b err=%b stb=%b memout=%h, required 1 1 0 ffff",
                     mem_rdy, bus_err, wb_stb_o, memout);
        end
        step();
    endtask

    task automatic test_back_to_back();
        start(20'h00040, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        wb_ack_i = 1'b1; wb_dat_i = 16'h1111;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, memout} !== {1'b1, 16'h1111}) begin
            n_fail++;
            $display("FAIL b2b_first: rdy=%b memout=%h, required 1 1111", mem_rdy, memout);
        end
        addr = 20'h00060;
        step();
        n_checks++;
        if ({wb_stb_o, mem_rdy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_idle: stb=%b rdy=%b, required 0 0", wb_stb_o, mem_rdy);
        end
        step();
        req = 1'b0;
        n_checks++;
        if ({wb_stb_o, wb_adr_o} !== {1'b1, 19'h00030}) begin
            n_fail++;
            $display("FAIL b2b_second_bus: stb=%b adr=%h, required 1 00030", wb_stb_o, wb_adr_o);
        end
        wb_ack_i = 1'b1; wb_dat_i = 16'h2222;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, memout} !== {1'b1, 16'h2222}) begin
            n_fail++;
            $display("FAIL b2b_second: rdy=%b memout=%h, required 1 2222", mem_rdy, memout);
        end
        step();
    endtask

    task automatic test_reset_mid();
        start(20'h00080, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({wb_stb_o, wb_cyc_o, mem_rdy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_async: stb=%b cyc=%b rdy=%b, required 0 0 0", wb_stb_o, wb_cyc_o, mem_rdy);
        end
        req = 1'b0;
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({wb_stb_o, mem_rdy} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_no_rdy%0d: stb=%b rdy=%b, required 0 0", i, wb_stb_o, mem_rdy);
            end
        end
        start(20'h00090, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        req = 1'b0;
        n_checks++;
        if ({wb_stb_o, wb_adr_o} !== {1'b1, 19'h00048}) begin
            n_fail++;
            $display("FAIL reset_fresh_bus: stb=%b adr=%h, required 1 00048", wb_stb_o, wb_adr_o);
        end
        wb_ack_i = 1'b1; wb_dat_i = 16'h4444;
        step();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({mem_rdy, bus_err, memout} !== {2'b10, 16'h4444}) begin
            n_fail++;
            $display("FAIL reset_fresh_done: rdy=%b err=%b memout=%h, required 1 0 4444", mem_rdy, bus_err, memout);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_byte_read();
        test_split_read();
        test_io_split_write();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
